mult_add_acc: RTL and testbench
===============================

Name: mult_add_acc

Overview:
- Parametrised, two-stage pipelined signed multiply-add with a pipelined valid flag.
- Two modes, selectable per sample:
  - Mode 0 (offset): s = a*b + (c << C_SHIFT).
  - Mode 1 (accumulate): s = running sum of a*b held in an internal accumulator.
- Adds overflow reporting, accumulator clear and reset.
- Sits in the datapath as a generic MAC element feeding filter and verification benches.

Parameters:
- DATA_W, 8: width of signed inputs a, b, c.
- OUT_W, 16: width of signed result and accumulator. Must satisfy OUT_W >= 2*DATA_W.
- C_SHIFT, 7: left shift applied to c in mode 0. Must satisfy C_SHIFT + DATA_W <= OUT_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- val_in  in  1  input sample valid.
- a  in  DATA_W  signed multiplicand.
- b  in  DATA_W  signed multiplier.
- c  in  DATA_W  signed offset operand (mode 0 only).
- mode  in  1  0 = offset, 1 = accumulate. Sampled with val_in.
- acc_clr  in  1  clear accumulator. Pipelined with the sample and honoured even when val_in=0.
- s  out  OUT_W  signed result.
- rdy_out  out  1  result valid pulse.
- ovf  out  1  overflow flag for the current result. Qualified by rdy_out.

Behaviour:
- Reset (rst=1 at a clock edge): s=0, rdy_out=0, ovf=0, accumulator=0, all stage registers and stage valids cleared. A sample in flight is discarded.
- Stage 1 (every edge, not in reset):
  - Register prod = a*b (2*DATA_W bits, sign-extended to OUT_W).
  - Register cterm = sign-extended c << C_SHIFT.
  - Register v1=val_in, mode1=mode, clr1=acc_clr.
- Stage 2, when v1=1:
  - Mode 0: sum = cterm + prod. s <= sum. Accumulator untouched unless clr1=1, in which case accumulator <= 0.
  - Mode 1 with clr1=1: sum = prod. Accumulator <= prod. s <= prod. A new sum starts with this sample.
  - Mode 1 with clr1=0: sum = accumulator + prod. Accumulator <= sum. s <= sum.
  - rdy_out <= 1.
- Stage 2, when v1=0:
  - rdy_out <= 0. s and ovf hold their values.
  - If clr1=1, accumulator <= 0.
- Latency: exactly 2 cycles, val_in to rdy_out. Throughput: 1 sample per cycle. No backpressure.
- Arithmetic:
  - The sum is computed in OUT_W+1 bits.
  - ovf <= 1 when the OUT_W+1-bit sum falls outside the signed OUT_W range; otherwise 0. Updated only on valid stage-2 cycles.
  - Default is wrap-around: s and the accumulator take the low OUT_W bits.
- Boundaries:
  - Mode 0 cannot overflow with default parameters.
  - Mode changes between consecutive samples need no bubble.
  - Back-to-back accumulate samples chain with no stall.

Optional Feature:
- Macro MULT_ADD_ACC_SAT_EN.
- When defined:
  - On overflow, s and the accumulator take +2^(OUT_W-1)-1 on positive overflow or -2^(OUT_W-1) on negative overflow.
  - ovf is still asserted.
- When undefined: wrap-around as described in Behaviour.

Decomposition:
- Package mult_add_pkg holds:
  - mode encoding constants MODE_OFFSET=0 and MODE_ACC=1.
  - function sat_clip(OUT_W+1-bit value) returning the OUT_W-bit saturated value plus an overflow bit. It is used only when MULT_ADD_ACC_SAT_EN is defined; the overflow-detect part is always used.
- No sub-module. Both stages live in mult_add_acc.

Test Plan:
1. Reset, then val_in=1, mode=0, a=3, b=4, c=1 -> two cycles later rdy_out=1, s=140, ovf=0. Next cycle rdy_out=0 and s holds 140.
2. Mode 0, a=-128, b=127, c=-128 -> s=-32640, ovf=0. Then a=-128, b=-128, c=127 on the next cycle -> s=32640 one cycle later.
3. Mode 1, acc_clr=1 with a=10, b=10, then acc_clr=0 with a=-5, b=4 and a=2, b=3 on consecutive cycles -> s=100, 80, 86 on three consecutive rdy_out cycles.
4. Mode 1, acc_clr=1 with a=-128, b=-128, then acc_clr=0 with the same operands:
   - Default build -> s=16384, then s=-32768 with ovf=1.
   - With MULT_ADD_ACC_SAT_EN -> s=32767, ovf=1.
5. Accumulate to 50, then a lone acc_clr=1 with val_in=0, then mode 1, a=1, b=1 -> s=1. No rdy_out is produced for the clear-only cycle.
6. rst asserted one cycle after val_in=1 -> no rdy_out follows, s=0. Accumulator is 0: the next mode-1 sample a=2, b=2 gives s=4.

Source files
------------

// File: rtl/mult_add_pkg.sv
// Shared definitions for the mult_add_acc MAC element: mode encodings and
// the overflow-detect / saturating clip helper.
package mult_add_pkg;

  localparam logic MODE_OFFSET = 1'b0;
  localparam logic MODE_ACC    = 1'b1;

  // Widest result the clip helper handles; callers sign-extend into it.
  localparam int MAX_W = 64;

  typedef struct packed {
    logic             ovf;
    logic [MAX_W-1:0] val;
  } clip_t;

  // v is a sign-extended sum; w is the target signed width (w < MAX_W).
  // ovf flags values outside the signed w-bit range; val is the clipped value.
  function automatic clip_t sat_clip(input logic signed [MAX_W:0] v,
                                     input int unsigned           w);
    clip_t                   r;
    logic signed [MAX_W:0]   one;
    logic signed [MAX_W:0]   hi;
    logic signed [MAX_W:0]   lo;
    one   = {{MAX_W{1'b0}}, 1'b1};
    hi    = (one << (w - 1)) - one;
    lo    = ~hi;
    r.ovf = (v > hi) || (v < lo);
    if (!r.ovf)        r.val = v[MAX_W-1:0];
    else if (v[MAX_W]) r.val = lo[MAX_W-1:0];
    else               r.val = hi[MAX_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/mult_add_acc.sv
// Two-stage pipelined signed multiply-add / accumulate.
// Stage 1 registers a*b and c<<C_SHIFT; stage 2 forms the sum in OUT_W+1 bits,
// flags overflow and updates the result and accumulator.
// Optional macro MULT_ADD_ACC_SAT_EN: saturate s and accumulator on overflow
// instead of wrapping.
module mult_add_acc
  import mult_add_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int OUT_W   = 16,
  parameter int C_SHIFT = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     val_in,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] c,
  input  logic                     mode,
  input  logic                     acc_clr,
  output logic signed [OUT_W-1:0]  s,
  output logic                     rdy_out,
  output logic                     ovf
);

  localparam int STAGES = 2;

  typedef struct packed {
    logic                    mode;
    logic                    clr;
    logic signed [OUT_W-1:0] prod;
    logic signed [OUT_W-1:0] cterm;
  } st1_t;

  logic [STAGES:1]           vld_pipe;
  st1_t                      st1;
  logic signed [OUT_W-1:0]   acc;

  logic signed [2*DATA_W-1:0] prod_full;
  logic signed [OUT_W-1:0]    prod_ext;
  logic signed [OUT_W-1:0]    c_ext;
  logic signed [OUT_W-1:0]    cterm_n;
  logic signed [OUT_W:0]      sum_w;
  clip_t                      clip;
  logic signed [OUT_W-1:0]    res;

  // Stage-1 operand shaping: full-precision product and shifted offset.
  always_comb begin
    prod_full = a * b;
    prod_ext  = prod_full;
    c_ext     = c;
    cterm_n   = c_ext <<< C_SHIFT;
  end

  // Stage-1 registers and valid pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      st1      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], val_in};
      st1      <= '{mode: mode, clr: acc_clr, prod: prod_ext, cterm: cterm_n};
    end
  end

  // Stage-2 sum in OUT_W+1 bits, overflow detect and result select.
  always_comb begin
    sum_w = '0;
    if (st1.mode == MODE_OFFSET)
      sum_w = {st1.cterm[OUT_W-1], st1.cterm} + {st1.prod[OUT_W-1], st1.prod};
    else if (st1.clr)
      sum_w = {st1.prod[OUT_W-1], st1.prod};
    else
      sum_w = {acc[OUT_W-1], acc} + {st1.prod[OUT_W-1], st1.prod};
    clip = sat_clip({{(MAX_W-OUT_W){sum_w[OUT_W]}}, sum_w}, OUT_W);
`ifdef MULT_ADD_ACC_SAT_EN
    res  = clip.val[OUT_W-1:0];
`else
    res  = sum_w[OUT_W-1:0];
`endif
  end

`ifdef MULT_ADD_ACC_SAT_EN
  logic unused_clip;
  assign unused_clip = ^clip.val[MAX_W-1:OUT_W];
`else
  logic unused_clip;
  assign unused_clip = ^clip.val;
`endif

  // Stage-2 registers: result, overflow flag and accumulator. A clear with
  // no valid sample still resets the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      s   <= '0;
      ovf <= 1'b0;
      acc <= '0;
    end else if (vld_pipe[1]) begin
      s   <= res;
      ovf <= clip.ovf;
      if (st1.mode == MODE_ACC) acc <= res;
      else if (st1.clr)         acc <= '0;
    end else if (st1.clr) begin
      acc <= '0;
    end
  end

  assign rdy_out = vld_pipe[STAGES];

endmodule

// File: tb/tb_mult_add_acc.sv
// Scoreboard bench for mult_add_acc: stimulus pushes expected results, a
// negedge monitor pops and compares on every rdy_out.
module tb_mult_add_acc;

  localparam int DATA_W = 8;
  localparam int OUT_W  = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     val_in;
  logic signed [DATA_W-1:0] a, b, c;
  logic                     mode;
  logic                     acc_clr;
  logic signed [OUT_W-1:0]  s;
  logic                     rdy_out;
  logic                     ovf;

  typedef struct {
    logic signed [OUT_W-1:0] s;
    logic                    ovf;
    string                   name;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_rdy  = 0;
  int   n_push = 0;

  mult_add_acc #(.DATA_W(DATA_W), .OUT_W(OUT_W), .C_SHIFT(7)) dut (
    .clk(clk), .rst(rst), .val_in(val_in), .a(a), .b(b), .c(c),
    .mode(mode), .acc_clr(acc_clr), .s(s), .rdy_out(rdy_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every result pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rdy_out) begin
      n_rdy++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rdy: got s=%0d with no expected result", s);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_s"}, longint'(s), longint'(e.s));
        check({e.name, "_ovf"}, longint'(ovf), longint'(e.ovf));
      end
    end
  end

  task automatic drive(input logic v, input logic m, input logic clr,
                       input int ai, input int bi, input int ci);
    @(posedge clk);
    #1;
    val_in  = v;
    mode    = m;
    acc_clr = clr;
    a       = DATA_W'(ai);
    b       = DATA_W'(bi);
    c       = DATA_W'(ci);
  endtask

  task automatic send(input logic m, input logic clr, input int ai, input int bi,
                      input int ci, input int es, input logic eo, input string nm);
    exp_t e;
    drive(1'b1, m, clr, ai, bi, ci);
    e.s   = OUT_W'(es);
    e.ovf = eo;
    e.name = nm;
    exp_q.push_back(e);
    n_push++;
  endtask

  task automatic idle(input logic clr);
    drive(1'b0, 1'b0, clr, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; val_in = 1'b0; mode = 1'b0; acc_clr = 1'b0;
    a = '0; b = '0; c = '0;
    repeat (3) @(negedge clk);
    check("reset_s", longint'(s), 0);
    check("reset_rdy", longint'(rdy_out), 0);
    check("reset_ovf", longint'(ovf), 0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: basic offset mode, then result holds
    send(1'b0, 1'b0, 3, 4, 1, 140, 1'b0, "t1");
    idle(1'b0);
    repeat (3) @(negedge clk);
    check("t1_rdy_low", longint'(rdy_out), 0);
    check("t1_s_hold", longint'(s), 140);

    // 2: mode 0 extremes, back-to-back
    send(1'b0, 1'b0, -128, 127, -128, -32640, 1'b0, "t2a");
    send(1'b0, 1'b0, -128, -128, 127, 32640, 1'b0, "t2b");

    // 3: accumulate chain with mode change and no bubble
    send(1'b1, 1'b1, 10, 10, 0, 100, 1'b0, "t3a");
    send(1'b1, 1'b0, -5, 4, 0, 80, 1'b0, "t3b");
    send(1'b1, 1'b0, 2, 3, 0, 86, 1'b0, "t3c");

    // 4: accumulator overflow
    send(1'b1, 1'b1, -128, -128, 0, 16384, 1'b0, "t4a");
`ifdef MULT_ADD_ACC_SAT_EN
    send(1'b1, 1'b0, -128, -128, 0, 32767, 1'b1, "t4b");
`else
    send(1'b1, 1'b0, -128, -128, 0, -32768, 1'b1, "t4b");
`endif

    // 5: clear-only cycle with val_in=0
    send(1'b1, 1'b1, 5, 10, 0, 50, 1'b0, "t5a");
    idle(1'b1);
    send(1'b1, 1'b0, 1, 1, 0, 1, 1'b0, "t5b");
    idle(1'b0);
    repeat (4) @(negedge clk);

    // 6: reset discards an in-flight sample and clears the accumulator
    drive(1'b1, 1'b1, 1'b0, 7, 7, 0);
    @(posedge clk); #1;
    rst = 1'b1; val_in = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_rdy_after_rst", longint'(rdy_out), 0);
    check("t6_s_after_rst", longint'(s), 0);
    send(1'b1, 1'b0, 2, 2, 0, 4, 1'b0, "t6b");
    idle(1'b0);

    // Bounded drain of outstanding expectations
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("drain_pending", longint'(exp_q.size()), 0);
    check("rdy_pulse_count", longint'(n_rdy), longint'(n_push));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
